// File: rtl/axi_b_rr_arbiter_pkg.sv
// Shared AXI B-channel definitions and small index helpers for the B-response arbiter.
package axi_b_rr_arbiter_pkg;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t RESP_OKAY   = 2'b00;
    localparam axi_resp_t RESP_EXOKAY = 2'b01;
    localparam axi_resp_t RESP_SLVERR = 2'b10;
    localparam axi_resp_t RESP_DECERR = 2'b11;

    // (base + offs) modulo n, used for the rotating priority scan and pointer advance.
    function automatic int unsigned rr_wrap(input int unsigned base,
                                            input int unsigned offs,
                                            input int unsigned n);
        return (base + offs) % n;
    endfunction

endpackage

// File: rtl/spill_register_flushable.sv
// Two-entry spill register with synchronous flush; Bypass=1 turns it into wires.
// Entry b always holds the older beat when both entries are occupied.
module spill_register_flushable #(
    parameter int unsigned Width  = 8,
    parameter bit          Bypass = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic             flush_i,
    output logic             ready_o,
    input  logic [Width-1:0] data_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] data_o
);

    if (Bypass) begin : g_bypass
        logic unused_bypass;
        assign unused_bypass = ^{clk_i, rst_ni, flush_i};
        assign valid_o = valid_i;
        assign ready_o = ready_i;
        assign data_o  = data_i;
    end else begin : g_spill
        logic             a_full_q, a_full_d, b_full_q, b_full_d;
        logic [Width-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
        logic             a_fill, a_drain, b_fill, b_drain;

        assign ready_o = ~a_full_q | ~b_full_q;
        assign valid_o = a_full_q | b_full_q;
        assign data_o  = b_full_q ? b_data_q : a_data_q;

        // Entry moves: a takes new beats, a spills into b when downstream stalls.
        always_comb begin
            a_fill   = valid_i & ready_o;
            a_drain  = a_full_q & ~b_full_q;
            b_fill   = a_drain & ~ready_i;
            b_drain  = b_full_q & ready_i;
            a_data_d = a_fill ? data_i : a_data_q;
            b_data_d = b_fill ? a_data_q : b_data_q;
            a_full_d = a_fill | (a_full_q & ~a_drain);
            b_full_d = b_fill | (b_full_q & ~b_drain);
            if (flush_i) begin
                a_full_d = 1'b0;
                b_full_d = 1'b0;
            end
        end

        // Entry storage; reset empties both and zeroes the data seen at data_o.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_full_q <= 1'b0;
                b_full_q <= 1'b0;
                a_data_q <= '0;
                b_data_q <= '0;
            end else begin
                a_full_q <= a_full_d;
                b_full_q <= b_full_d;
                a_data_q <= a_data_d;
                b_data_q <= b_data_d;
            end
        end
    end

endmodule

// File: rtl/axi_b_rr_arbiter.sv
// Round-robin arbiter sharing one AXI B channel among NumInp sources.
// The grant is held on a stalled requester (LockIn) so the offered beat never changes
// underneath a waiting downstream; the winner and its index leave through a spill register.
module axi_b_rr_arbiter
    import axi_b_rr_arbiter_pkg::*;
#(
    parameter int unsigned  NumInp    = 4,
    parameter int unsigned  IdWidth   = 4,
    parameter int unsigned  UserWidth = 1,
    parameter bit           LockIn    = 1'b1,
    parameter bit           SpillReg  = 1'b1,
    localparam int unsigned BW        = IdWidth + 2 + UserWidth,
    localparam int unsigned IdxW      = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [NumInp-1:0]    inp_valid_i,
    output logic [NumInp-1:0]    inp_ready_o,
    input  logic [NumInp*BW-1:0] inp_data_i,
    output logic                 oup_valid_o,
    input  logic                 oup_ready_i,
    output logic [BW-1:0]        oup_data_o,
    output logic [IdxW-1:0]      oup_idx_o
);

    typedef logic [IdxW-1:0] idx_t;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        axi_resp_t            resp;
        logic [UserWidth-1:0] user;
    } b_chan_t;

    b_chan_t inp_beat [NumInp];

    for (genvar i = 0; i < NumInp; i++) begin : g_unpack
        assign inp_beat[i] = b_chan_t'(inp_data_i[i*BW +: BW]);
    end

    idx_t                rr_q, rr_d, lock_idx_q, lock_idx_d;
    logic                lock_q, lock_d;
    idx_t                gnt_idx, cand_idx;
    logic                gnt_found;
    logic                int_valid, int_ready, int_hs;
    logic [BW+IdxW-1:0]  int_data, oup_word;

    // Priority scan starting at rr_q; a held lock overrides the scan result.
    always_comb begin
        gnt_idx   = rr_q;
        cand_idx  = '0;
        gnt_found = 1'b0;
        for (int unsigned k = 0; k < NumInp; k++) begin
            cand_idx = idx_t'(rr_wrap(32'(rr_q), k, NumInp));
            if (!gnt_found && inp_valid_i[cand_idx]) begin
                gnt_idx   = cand_idx;
                gnt_found = 1'b1;
            end
        end
        if (lock_q) begin
            gnt_idx = lock_idx_q;
        end
    end

    assign int_valid = (|inp_valid_i) & ~flush_i;
    assign int_hs    = int_valid & int_ready;
    assign int_data  = {inp_beat[gnt_idx], gnt_idx};

    // Only the granted requester sees ready, and only when the beat is actually taken.
    always_comb begin
        inp_ready_o = '0;
        for (int unsigned i = 0; i < NumInp; i++) begin
            if (idx_t'(i) == gnt_idx) begin
                inp_ready_o[i] = int_hs;
            end
        end
    end

    // Pointer advances past the winner on a handshake; a stall pins the grant.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (flush_i) begin
            lock_d = 1'b0;
        end else if (int_hs) begin
            rr_d   = idx_t'(rr_wrap(32'(gnt_idx), 1, NumInp));
            lock_d = 1'b0;
        end else if (LockIn && int_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = gnt_idx;
        end
    end

    // Arbiter state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    spill_register_flushable #(
        .Width  (BW + IdxW),
        .Bypass (!SpillReg)
    ) i_spill (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (int_valid),
        .flush_i (flush_i),
        .ready_o (int_ready),
        .data_i  (int_data),
        .valid_o (oup_valid_o),
        .ready_i (oup_ready_i),
        .data_o  (oup_word)
    );

    assign {oup_data_o, oup_idx_o} = oup_word;

    // A locked requester withdrawing its beat breaks AXI stability; ready stays one-hot.
    a_lock_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (lock_q && !flush_i) |-> inp_valid_i[lock_idx_q]);
    a_ready_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(inp_ready_o));

endmodule

// File: tb/tb_axi_b_rr_arbiter.sv
// Bench for axi_b_rr_arbiter: a queue-based model of the arbiter and output buffer is
// compared against the registered instance every cycle; directed literals pin key cycles.
module tb_axi_b_rr_arbiter;
    import axi_b_rr_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int BW = 7;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush = 1'b0;
    logic [N-1:0]  vld = '0;
    logic [N*BW-1:0] dat = '0;
    logic          o_ready = 1'b0;
    logic [N-1:0]  rdy;
    logic          ov;
    logic [BW-1:0] od;
    logic [1:0]    oi;

    logic [N-1:0]  vld2 = '0;
    logic [N*BW-1:0] dat2 = '0;
    logic          ordy2 = 1'b0;
    logic [N-1:0]  rdy2;
    logic          ov2;
    logic [BW-1:0] od2;
    logic [1:0]    oi2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic [BW-1:0] rq [N][$];
    logic [BW+1:0] mq [$];
    int   rr_m = 0, lock_idx_m = 0, g_m = 0;
    bit   lock_m = 1'b0;
    bit   any_m, iv_m, ir_m, found_m;
    logic [N-1:0] expr_m;

    always #5 clk_i = ~clk_i;

    axi_b_rr_arbiter u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush),
        .inp_valid_i(vld), .inp_ready_o(rdy), .inp_data_i(dat),
        .oup_valid_o(ov), .oup_ready_i(o_ready), .oup_data_o(od), .oup_idx_o(oi)
    );

    axi_b_rr_arbiter #(.SpillReg(1'b0)) u_byp (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(1'b0),
        .inp_valid_i(vld2), .inp_ready_o(rdy2), .inp_data_i(dat2),
        .oup_valid_o(ov2), .oup_ready_i(ordy2), .oup_data_o(od2), .oup_idx_o(oi2)
    );

    function automatic logic [BW-1:0] mk(input logic [3:0] id, input logic [1:0] resp,
                                         input logic user);
        return {id, resp, user};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            vld[i]           = (rq[i].size() != 0);
            dat[i*BW +: BW]  = (rq[i].size() != 0) ? rq[i][0] : '0;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        refresh();
    endtask

    // Model: compare this cycle's outputs, then advance the model to the next cycle.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                mq.delete();
                rr_m = 0; lock_m = 1'b0; lock_idx_m = 0;
            end else if (chk_en) begin
                any_m = (vld != '0);
                iv_m  = any_m && !flush;
                ir_m  = (mq.size() < 2);
                g_m   = rr_m;
                found_m = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (!found_m && vld[(rr_m + k) % N]) begin
                        g_m = (rr_m + k) % N;
                        found_m = 1'b1;
                    end
                end
                if (lock_m) g_m = lock_idx_m;
                expr_m = (iv_m && ir_m) ? N'(1 << g_m) : '0;
                chk("model_inp_ready", 32'(rdy), 32'(expr_m));
                chk("model_oup_valid", 32'(ov), 32'(mq.size() != 0));
                if (mq.size() != 0) begin
                    chk("model_oup_data", 32'(od), 32'(mq[0][BW+1:2]));
                    chk("model_oup_idx", 32'(oi), 32'(mq[0][1:0]));
                end
                if (flush) begin
                    mq.delete();
                    lock_m = 1'b0;
                end else begin
                    if (mq.size() != 0 && o_ready) void'(mq.pop_front());
                    if (iv_m && ir_m) begin
                        mq.push_back({rq[g_m][0], 2'(g_m)});
                        void'(rq[g_m].pop_front());
                        rr_m   = (g_m + 1) % N;
                        lock_m = 1'b0;
                    end else if (iv_m) begin
                        lock_m     = 1'b1;
                        lock_idx_m = g_m;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] seq_rdy [5];
        logic [1:0]   seq_idx [5];
        seq_rdy = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_oup_valid", 32'(ov), 0);
        chk("rst_oup_data", 32'(od), 0);
        chk("rst_oup_idx", 32'(oi), 0);
        chk("rst_inp_ready", 32'(rdy), 0);
        rst_ni = 1'b1;
        tick();
        chk_en = 1'b1;

        // Bypass instance: same-cycle pass-through with SLVERR preserved
        @(negedge clk_i);
        #1;
        vld2 = 4'b0010;
        dat2[1*BW +: BW] = mk(4'd3, RESP_SLVERR, 1'b1);
        ordy2 = 1'b1;
        #1;
        chk("byp_oup_valid", 32'(ov2), 1);
        chk("byp_inp_ready", 32'(rdy2), 32'(4'b0010));
        chk("byp_oup_data", 32'(od2), 32'(7'b0011_10_1));
        chk("byp_resp", 32'(od2[2:1]), 32'(2'b10));
        chk("byp_oup_idx", 32'(oi2), 1);
        ordy2 = 1'b0;
        #1;
        chk("byp_stall_ready", 32'(rdy2), 0);
        chk("byp_stall_valid", 32'(ov2), 1);
        vld2 = '0;

        // Test 1: all valid, rotating grants one per cycle
        tick();
        for (int i = 0; i < N; i++) rq[i].push_back(mk(4'(i + 1), RESP_OKAY, 1'b0));
        rq[0].push_back(mk(4'hF, RESP_EXOKAY, 1'b1));
        o_ready = 1'b1;
        refresh();
        for (int j = 0; j < 5; j++) begin
            @(negedge clk_i);
            chk("t1_grant", 32'(rdy), 32'(seq_rdy[j]));
            if (j > 0) chk("t1_oup_idx", 32'(oi), 32'(seq_idx[j-1]));
            tick();
        end
        @(negedge clk_i);
        chk("t1_last_idx", 32'(oi), 0);
        tick();
        tick();

        // Test 2: two beats buffered while downstream stalls, then released in order
        o_ready = 1'b0;
        rq[1].push_back(mk(4'd5, RESP_OKAY, 1'b0));
        rq[3].push_back(mk(4'd9, RESP_OKAY, 1'b0));
        refresh();
        tick();
        tick();
        @(negedge clk_i);
        chk("t2_full_ready", 32'(rdy), 0);
        chk("t2_full_valid", 32'(ov), 1);
        chk("t2_head_data", 32'(od), 32'(7'b0101_00_0));
        tick();
        o_ready = 1'b1;
        @(negedge clk_i);
        chk("t2_out0_data", 32'(od), 32'(7'b0101_00_0));
        chk("t2_out0_idx", 32'(oi), 1);
        tick();
        @(negedge clk_i);
        chk("t2_out1_data", 32'(od), 32'(7'b1001_00_0));
        chk("t2_out1_idx", 32'(oi), 3);
        tick();
        @(negedge clk_i);
        chk("t2_empty", 32'(ov), 0);
        tick();

        // Test 3: lock holds grant on stalled input 2 despite input 0 arriving
        o_ready = 1'b0;
        rq[1].push_back(mk(4'd1, RESP_OKAY, 1'b0));
        rq[3].push_back(mk(4'd3, RESP_OKAY, 1'b0));
        refresh();
        tick();
        tick();
        rq[2].push_back(mk(4'hA, RESP_SLVERR, 1'b0));
        refresh();
        tick();
        rq[0].push_back(mk(4'hC, RESP_DECERR, 1'b1));
        o_ready = 1'b1;
        refresh();
        @(negedge clk_i);
        chk("t3_stall_ready", 32'(rdy), 0);
        tick();
        @(negedge clk_i);
        chk("t3_locked_grant", 32'(rdy), 32'(4'b0100));
        tick();
        @(negedge clk_i);
        chk("t3_after_lock", 32'(rdy), 32'(4'b0001));
        for (int t = 0; t < 10 && (ov || vld != '0); t++) tick();
        @(negedge clk_i);
        chk("t3_drained", 32'(ov), 0);
        tick();

        // Test 4: flush drops two buffered beats and releases the lock
        o_ready = 1'b0;
        rq[1].push_back(mk(4'd4, RESP_OKAY, 1'b0));
        rq[2].push_back(mk(4'd6, RESP_OKAY, 1'b0));
        rq[3].push_back(mk(4'd7, RESP_EXOKAY, 1'b0));
        refresh();
        tick();
        tick();
        tick();
        flush = 1'b1;
        @(negedge clk_i);
        chk("t4_flush_ready", 32'(rdy), 0);
        chk("t4_flush_valid", 32'(ov), 1);
        tick();
        flush = 1'b0;
        @(negedge clk_i);
        chk("t4_post_flush_valid", 32'(ov), 0);
        chk("t4_post_flush_grant", 32'(rdy), 32'(4'b1000));
        tick();
        @(negedge clk_i);
        chk("t4_new_beat_valid", 32'(ov), 1);
        chk("t4_new_beat_data", 32'(od), 32'(7'b0111_01_0));
        chk("t4_new_beat_idx", 32'(oi), 3);
        tick();
        o_ready = 1'b1;
        for (int t = 0; t < 10 && (ov || vld != '0); t++) tick();
        tick();

        // Test 6: reset with two beats buffered
        o_ready = 1'b0;
        rq[0].push_back(mk(4'd1, RESP_OKAY, 1'b0));
        rq[1].push_back(mk(4'd2, RESP_OKAY, 1'b0));
        rq[2].push_back(mk(4'd3, RESP_OKAY, 1'b0));
        refresh();
        tick();
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(ov), 0);
        chk("t6_rst_data", 32'(od), 0);
        chk("t6_rst_idx", 32'(oi), 0);
        rq[0].push_back(mk(4'hE, RESP_OKAY, 1'b0));
        refresh();
        tick();
        tick();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("t6_first_grant", 32'(rdy), 32'(4'b0001));
        tick();
        o_ready = 1'b1;
        for (int t = 0; t < 20 && (ov || vld != '0); t++) tick();
        @(negedge clk_i);
        chk("t6_drained", 32'(ov), 0);
        chk("t6_queues_empty", 32'(vld), 0);
        tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
